mfp_lcd_ctrl: RTL and testbench
===============================

# mfp_lcd_ctrl

Command and framebuffer sequencer for the Nokia 5110-class LCD path in MIPSfpga. It sits directly upstream of the LCD SPI serializer. After reset it drives the panel reset pulse and the init command list. On each `start` request it streams a 504-byte framebuffer (84×48, 1 bpp) held in on-block RAM that the CPU writes. Each byte is handed to the serializer over the `value`/`ctrl`/`send`/`spi_ready` handshake.

## Interface
- `DELAY_WIDTH`, 20: width of the panel-reset delay counter; each reset phase lasts 2^DELAY_WIDTH cycles.
- `FB_BYTES`, 504: framebuffer size in bytes; the address width is fixed at 9.
- `clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle refresh request.
- `bl_on`  in  1  backlight enable, passed through to `ctrl[1]`.
- `wr_en`  in  1  framebuffer write strobe.
- `wr_addr`  in  9  framebuffer write address.
- `wr_data`  in  8  framebuffer write data.
- `spi_ready`  in  1  serializer idle flag (its `ce`); 1 = idle and able to accept a byte.
- `value`  out  8  byte to the serializer.
- `ctrl`  out  3  `[0]` D/C (1 = data), `[1]` backlight, `[2]` panel reset_n.
- `send`  out  1  one-cycle load strobe to the serializer.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at the end of a refresh.

## Operation
- Reset values: `value`=0, `ctrl`=3'b000, `send`=0, `busy`=1, `done`=0, state RST_LO, delay counter 0, byte index 0, pending flag 0. Framebuffer contents are not reset.
- Top-level states:
  - RST_LO: `ctrl[2]`=0 for 2^DELAY_WIDTH cycles, then go to RST_HI.
  - RST_HI: `ctrl[2]`=1 for 2^DELAY_WIDTH cycles, then go to INIT.
  - INIT: send 6 commands (`ctrl[0]`=0) from a fixed ROM in this order: 0x21, 0xC8, 0x06, 0x13, 0x20, 0x0C. Then go to IDLE.
  - IDLE: `busy`=0. On `start`, or on a set pending flag, go to SET_X.
  - SET_X: send command 0x80, then go to SET_Y.
  - SET_Y: send command 0x40, then go to STREAM.
  - STREAM: send FB_BYTES data bytes (`ctrl[0]`=1) for index 0..FB_BYTES-1. After the last byte completes, pulse `done` and go to IDLE.
- Per-byte handshake sub-states:
  - ISSUE: wait for `spi_ready`=1, then assert `send` for exactly one cycle.
  - WAIT_BUSY: wait for `spi_ready`=0.
  - WAIT_IDLE: wait for `spi_ready`=1; the byte is then complete and the sequencer advances.
- `value` and `ctrl[0]` are set up at least one cycle before `send`. They are held stable from `send` until WAIT_IDLE exits.
- `ctrl[2]` stays 1 in every state after RST_HI. `ctrl[1]` = `bl_on` registered one cycle in all states, including RST_LO and RST_HI.
- Framebuffer RAM:
  - 504×8, one write port and one read port, with a registered (1-cycle) read.
  - The read address is the byte index. Read data is captured into `value` in the cycle before ISSUE.
  - A write with `wr_addr` ≥ FB_BYTES is ignored.
  - Writes are accepted in every state. A byte rewritten during STREAM goes out with its old or new value depending on whether it was read before or after the write; the stream is never corrupted beyond that single byte.
- A `start` while `busy`=1 sets the one-deep pending flag; further `start`s while pending are dropped. The pending flag clears on the IDLE→SET_X transition.
- The index counter is 9 bits, counts 0..FB_BYTES-1, and resets to 0 on entry to SET_X. It never wraps inside a refresh.
- `i_rst_n` asserted mid-transfer aborts immediately: all outputs return to their reset values and a full panel reset and init sequence follows.

## Timing
- `send` is high for exactly 1 cycle per byte and is never asserted while `spi_ready`=0.
- Accepting a byte: ISSUE sees `spi_ready`=1 → `send` rises on the next clock edge.
- `done` rises 1 cycle after `spi_ready` returns high following the final data byte.
- `busy` falls on the same edge that `done` rises.
- `start` in IDLE → `busy`=1 on the next edge. The 0x80 `send` follows within 3 cycles if `spi_ready`=1.
- Total refresh = 2 + FB_BYTES serializer transactions plus at most 3 cycles of overhead per byte.

## Test plan
- Reset release with DELAY_WIDTH=4 → `ctrl[2]`=0 for 16 cycles, then 1 for 16 cycles. Then 6 `send` pulses with `value` = 0x21, 0xC8, 0x06, 0x13, 0x20, 0x0C and `ctrl[0]`=0, then `busy`=0.
- Write 0xA5 to address 0 and 0x3C to address 503, then pulse `start` → command sends 0x80 and 0x40, then 504 data sends with `ctrl[0]`=1. The first data byte is 0xA5, the last is 0x3C, and `done` pulses once.
- Serializer model holds `spi_ready`=0 for a random 10–40 cycles per byte → exactly one `send` per byte, and `value`/`ctrl[0]` stay stable until `spi_ready` returns to 1.
- Two `start` pulses mid-refresh → exactly one extra refresh follows (two `done` pulses in total); a write to address 504 leaves addresses 0 and 503 unchanged.
- `i_rst_n` low during byte 200 of STREAM → next cycle `send`=0, `ctrl`=3'b000, `busy`=1; after release the full reset and init sequence repeats.
- `bl_on` toggled during STREAM → `ctrl[1]` follows 1 cycle later with no extra `send` pulses.

Source files
------------

// File: rtl/mfp_lcd_ctrl.sv
// rtl/mfp_lcd_ctrl.sv - LCD command/framebuffer sequencer feeding the SPI serializer
// Panel reset, init command list, then on request X/Y address commands and a full framebuffer stream.
module mfp_lcd_ctrl #(
    parameter int DELAY_WIDTH = 20,
    parameter int FB_BYTES    = 504
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       start_i,
    input  logic       bl_on_i,
    input  logic       wr_en_i,
    input  logic [8:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       spi_ready_i,
    output logic [7:0] value_o,
    output logic [2:0] ctrl_o,
    output logic       send_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [8:0] FB_LIMIT = 9'(FB_BYTES);
    localparam logic [8:0] LAST_IDX = 9'(FB_BYTES - 1);
    localparam logic [8:0] LAST_CMD = 9'd5;

    typedef enum logic [2:0] {
        ST_RST_LO,
        ST_RST_HI,
        ST_INIT,
        ST_IDLE,
        ST_SET_X,
        ST_SET_Y,
        ST_STREAM
    } state_t;

    typedef enum logic [2:0] {
        HS_FETCH,
        HS_LOAD,
        HS_ISSUE,
        HS_WAIT_BUSY,
        HS_WAIT_IDLE
    } hs_t;

    state_t                 state_q, state_d;
    hs_t                    hs_q, hs_d;
    logic [DELAY_WIDTH-1:0] dly_q, dly_d;
    logic [8:0]             idx_q, idx_d;
    logic                   pend_q, pend_d;
    logic [7:0]             value_q, value_d;
    logic                   dc_q, dc_d;
    logic                   send_q, send_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   panel_q, panel_d;
    logic                   bl_q;

    logic [7:0] mem [FB_BYTES];
    logic [7:0] rd_data_q;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    init_cmd = 8'h21;
            3'd1:    init_cmd = 8'hC8;
            3'd2:    init_cmd = 8'h06;
            3'd3:    init_cmd = 8'h13;
            3'd4:    init_cmd = 8'h20;
            default: init_cmd = 8'h0C;
        endcase
    endfunction

    // Framebuffer: no reset; read port follows the byte index every cycle.
    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_addr_i < FB_LIMIT)) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem[idx_q];
    end

    always_comb begin
        state_d = state_q;
        hs_d    = hs_q;
        dly_d   = dly_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        value_d = value_q;
        dc_d    = dc_q;
        send_d  = 1'b0;
        done_d  = 1'b0;

        if (start_i && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_RST_LO: begin
                dly_d = dly_q + DELAY_WIDTH'(1);
                if (&dly_q) begin
                    state_d = ST_RST_HI;
                end
            end
            ST_RST_HI: begin
                dly_d = dly_q + DELAY_WIDTH'(1);
                if (&dly_q) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                    hs_d    = HS_LOAD;
                end
            end
            ST_IDLE: begin
                if (start_i || pend_q) begin
                    state_d = ST_SET_X;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    hs_d    = HS_LOAD;
                end
            end
            default: begin
                // Shared per-byte handshake for INIT, SET_X, SET_Y and STREAM.
                case (hs_q)
                    HS_FETCH: hs_d = HS_LOAD;
                    HS_LOAD: begin
                        case (state_q)
                            ST_INIT:  value_d = init_cmd(idx_q[2:0]);
                            ST_SET_X: value_d = 8'h80;
                            ST_SET_Y: value_d = 8'h40;
                            default:  value_d = rd_data_q;
                        endcase
                        dc_d = (state_q == ST_STREAM);
                        hs_d = HS_ISSUE;
                    end
                    HS_ISSUE: begin
                        if (spi_ready_i) begin
                            send_d = 1'b1;
                            hs_d   = HS_WAIT_BUSY;
                        end
                    end
                    HS_WAIT_BUSY: begin
                        if (!spi_ready_i) begin
                            hs_d = HS_WAIT_IDLE;
                        end
                    end
                    HS_WAIT_IDLE: begin
                        if (spi_ready_i) begin
                            case (state_q)
                                ST_INIT: begin
                                    if (idx_q == LAST_CMD) begin
                                        state_d = ST_IDLE;
                                    end else begin
                                        idx_d = idx_q + 9'd1;
                                        hs_d  = HS_LOAD;
                                    end
                                end
                                ST_SET_X: begin
                                    state_d = ST_SET_Y;
                                    hs_d    = HS_LOAD;
                                end
                                ST_SET_Y: begin
                                    state_d = ST_STREAM;
                                    hs_d    = HS_FETCH;
                                end
                                default: begin
                                    if (idx_q == LAST_IDX) begin
                                        state_d = ST_IDLE;
                                        done_d  = 1'b1;
                                    end else begin
                                        idx_d = idx_q + 9'd1;
                                        hs_d  = HS_FETCH;
                                    end
                                end
                            endcase
                        end
                    end
                    default: hs_d = HS_FETCH;
                endcase
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        panel_d = (state_d != ST_RST_LO);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RST_LO;
            hs_q    <= HS_FETCH;
            dly_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            value_q <= '0;
            dc_q    <= 1'b0;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            panel_q <= 1'b0;
            bl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            value_q <= value_d;
            dc_q    <= dc_d;
            send_q  <= send_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            panel_q <= panel_d;
            bl_q    <= bl_on_i;
        end
    end

    assign value_o = value_q;
    assign ctrl_o  = {panel_q, bl_q, dc_q};
    assign send_o  = send_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_mfp_lcd_ctrl.sv
// tb/tb_mfp_lcd_ctrl.sv - scoreboard bench for mfp_lcd_ctrl with a randomized serializer model
module tb_mfp_lcd_ctrl;

    localparam int DW = 4;
    localparam int FB = 504;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       start;
    logic       bl_on;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       spi_ready;
    logic [7:0] value;
    logic [2:0] ctrl;
    logic       send;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    mfp_lcd_ctrl #(.DELAY_WIDTH(DW), .FB_BYTES(FB)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .start_i    (start),
        .bl_on_i    (bl_on),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .spi_ready_i(spi_ready),
        .value_o    (value),
        .ctrl_o     (ctrl),
        .send_o     (send),
        .busy_o     (busy),
        .done_o     (done)
    );

    int         total = 0;
    int         bad = 0;
    int         data_sends = 0;
    int         done_cnt = 0;
    logic [8:0] exp_q[$];
    logic [7:0] fb[FB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h21});
        exp_q.push_back({1'b0, 8'hC8});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h13});
        exp_q.push_back({1'b0, 8'h20});
        exp_q.push_back({1'b0, 8'h0C});
    endtask

    task automatic push_refresh();
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b0, 8'h40});
        for (int i = 0; i < FB; i++) exp_q.push_back({1'b1, fb[i]});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic release_and_check();
        int lo;
        int hi;
        int n;
        @(posedge clk); #1 i_rst_n = 1'b1;
        lo = 0;
        @(negedge clk);
        while (ctrl[2] == 1'b0 && lo < 200) begin
            lo++;
            @(negedge clk);
        end
        check("rst_lo_cycles", lo, 16);
        check("bl_in_rst_hi", ctrl[1], 1'b1);
        hi = 0;
        while (!send && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        check("rst_hi_cycles_16_to_19", (hi >= 16 && hi <= 19), 1'b1);
        n = 0;
        while (busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("init_to_idle", busy, 1'b0);
        check("init_all_sent", exp_q.size(), 0);
        check("panel_rst_high", ctrl[2], 1'b1);
    endtask

    // Serializer: drops ready the cycle after a load, stays busy 10-40 cycles.
    initial begin
        spi_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (send) begin
                @(posedge clk); #1 spi_ready = 1'b0;
                repeat ($urandom_range(10, 40)) @(posedge clk);
                #1 spi_ready = 1'b1;
            end
        end
    end

    // Byte monitor: pops the scoreboard on every load and watches the hold window.
    initial begin
        logic [8:0] got;
        logic [8:0] e;
        logic       stable;
        logic       seen_low;
        int         n;
        forever begin
            @(negedge clk);
            if (i_rst_n && send) begin
                got = {ctrl[0], value};
                check("ready_at_send", spi_ready, 1'b1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_send: got 0x%0h want none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", got, e);
                end
                if (ctrl[0]) data_sends++;
                stable = 1'b1;
                seen_low = 1'b0;
                n = 0;
                while (!(seen_low && spi_ready) && n < 100) begin
                    @(negedge clk);
                    n++;
                    if (!i_rst_n) break;
                    if (!spi_ready) seen_low = 1'b1;
                    if ({ctrl[0], value} !== got || send) stable = 1'b0;
                end
                if (n >= 100) stable = 1'b0;
                if (i_rst_n) check("hold_single_send", stable, 1'b1);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 1'b0);
            end
        end
    end

    initial begin
        int n;
        int base;
        i_rst_n = 1'b0;
        start   = 1'b0;
        bl_on   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", value, 8'h00);
        check("rst_ctrl", ctrl, 3'b000);
        check("rst_send", send, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_done", done, 1'b0);

        push_init();
        release_and_check();

        for (int a = 0; a < FB; a++) begin
            fb[a] = (a == 0) ? 8'hA5 : (a == FB - 1) ? 8'h3C : 8'((a * 7 + 3) & 255);
            @(posedge clk); #1;
            wr_en = 1'b1;
            wr_addr = 9'(a);
            wr_data = fb[a];
        end
        @(posedge clk); #1 wr_en = 1'b0;

        push_refresh();
        pulse_start();
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);

        n = 0;
        while (data_sends < 50 && n < 20000) begin
            n++;
            @(negedge clk);
        end
        check("stream_progress", (data_sends >= 50), 1'b1);
        pulse_start();
        pulse_start();
        push_refresh();
        @(posedge clk); #1;
        wr_en = 1'b1;
        wr_addr = 9'd504;
        wr_data = 8'hFF;
        @(posedge clk); #1 wr_en = 1'b0;

        @(posedge clk); #1 bl_on = 1'b0;
        @(negedge clk);
        check("bl_old_before_edge", ctrl[1], 1'b1);
        @(negedge clk);
        check("bl_follows_1cyc", ctrl[1], 1'b0);
        @(posedge clk); #1 bl_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bl_back_on", ctrl[1], 1'b1);

        n = 0;
        while (!(done_cnt == 2 && !busy) && n < 70000) begin
            n++;
            @(negedge clk);
        end
        check("two_refreshes_done", done_cnt, 2);
        check("refresh_queue_empty", exp_q.size(), 0);
        repeat (200) @(negedge clk);
        check("no_third_refresh", done_cnt, 2);
        check("idle_after_pending", busy, 1'b0);

        base = data_sends;
        push_refresh();
        pulse_start();
        n = 0;
        while (data_sends < base + 201 && n < 20000) begin
            n++;
            @(negedge clk);
        end
        check("reached_byte_200", (data_sends >= base + 201), 1'b1);
        @(posedge clk); #1 i_rst_n = 1'b0;
        @(negedge clk);
        check("abort_send", send, 1'b0);
        check("abort_ctrl", ctrl, 3'b000);
        check("abort_busy", busy, 1'b1);
        check("abort_value", value, 8'h00);
        exp_q.delete();
        push_init();
        repeat (50) @(posedge clk);
        release_and_check();
        check("no_done_after_abort", done_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
